// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC flit-type codes, output port indices and requester FSM states
package noc_pkg;
  localparam int OUT_N = 5;
  localparam int SEL_W = $clog2(OUT_N);
  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;
  localparam logic [SEL_W-1:0] PORT_LOCAL = SEL_W'(0);
  localparam logic [SEL_W-1:0] PORT_NORTH = SEL_W'(1);
  localparam logic [SEL_W-1:0] PORT_EAST  = SEL_W'(2);
  localparam logic [SEL_W-1:0] PORT_SOUTH = SEL_W'(3);
  localparam logic [SEL_W-1:0] PORT_WEST  = SEL_W'(4);
  typedef enum logic [1:0] {IDLE, REQ, XFER} req_state_e;
endpackage

// File: rtl/xy_route.sv
// xy_route: XY dimension-order route; dest_x/dest_y + router_x/router_y in, output port index out
module xy_route
  import noc_pkg::*;
#(
  parameter int COORD_W = 2
) (
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  input  logic [COORD_W-1:0] router_x,
  input  logic [COORD_W-1:0] router_y,
  output logic [SEL_W-1:0]   port
);
  assign port = dest_x > router_x ? PORT_EAST  :
                dest_x < router_x ? PORT_WEST  :
                dest_y > router_y ? PORT_NORTH :
                dest_y < router_y ? PORT_SOUTH : PORT_LOCAL;
endmodule

// File: rtl/noc_input_requester.sv
// noc_input_requester: input-port packet requester; FIFO flit in, one-hot req/lock to arbiters, flit to crossbar, sel/err status out
module noc_input_requester #(
  parameter int FLIT_W   = 16,
  parameter int COORD_W  = 2,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int OUT_N    = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [FLIT_W-1:0]        flit_i,
  input  logic                     flit_valid_i,
  output logic                     flit_ready_o,
  output logic [OUT_N-1:0]         req_o,
  input  logic [OUT_N-1:0]         grant_i,
  output logic [OUT_N-1:0]         lock_o,
  output logic [FLIT_W-1:0]        xbar_flit_o,
  output logic                     xbar_valid_o,
  input  logic [OUT_N-1:0]         out_ready_i,
  output logic [$clog2(OUT_N)-1:0] sel_o,
  output logic                     err_o
);
  import noc_pkg::*;
  localparam int SW = $clog2(OUT_N);
  req_state_e state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] route;
  logic err_q, err_d;
  logic [1:0] ftype;
  logic is_head, is_tail, moved;
  logic [OUT_N-1:0] sel_oh;
  assign ftype   = flit_i[FLIT_W-1 -: 2];
  assign is_head = ftype == FLIT_HEAD || ftype == FLIT_HEAD_TAIL;
  assign is_tail = ftype == FLIT_TAIL || ftype == FLIT_HEAD_TAIL;
  assign moved   = flit_valid_i && out_ready_i[sel_q];
  assign sel_oh  = OUT_N'(1) << sel_q;
  xy_route #(.COORD_W(COORD_W)) u_route (
    .dest_x  (flit_i[COORD_W-1:0]),
    .dest_y  (flit_i[2*COORD_W-1:COORD_W]),
    .router_x(COORD_W'(ROUTER_X)),
    .router_y(COORD_W'(ROUTER_Y)),
    .port    (route)
  );
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    err_d        = 1'b0;
    req_o        = '0;
    lock_o       = '0;
    xbar_flit_o  = '0;
    xbar_valid_o = 1'b0;
    flit_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_d   = flit_valid_i && is_head ? SW'(route) : sel_q;
        state_d = flit_valid_i && is_head ? REQ : IDLE;
        // orphan BODY/TAIL is popped and dropped; the pop is gated so reset never consumes a flit
        flit_ready_o = flit_valid_i && !is_head && rst_ni;
        err_d        = flit_valid_i && !is_head;
      end
      REQ: begin
        req_o   = sel_oh;
        state_d = grant_i[sel_q] ? XFER : REQ;
      end
      XFER: begin
        lock_o       = sel_oh;
        xbar_flit_o  = flit_i;
        xbar_valid_o = flit_valid_i;
        flit_ready_o = out_ready_i[sel_q];
        state_d      = moved && is_tail ? IDLE : XFER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end
  assign sel_o = sel_q;
  assign err_o = err_q;
endmodule
